// File: rtl/input_port_buffer.sv
// input_port_buffer: per-port flit FIFO with a packet-framing FSM.
// Non-header flits seen while idle are dropped; a header at the head starts
// a packet that is forwarded on grants until a tail is popped.
// Optional build macro INPUT_BUF_DROP_COUNT_EN enables the saturating
// drop counter; otherwise drop_cnt is tied to zero.
module input_port_buffer #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [FLIT_W-1:0] flit_out,
  output logic [2:0]        flit_id,
  output logic [11:0]       length,
  output logic              req,
  input  logic              gnt,
  output logic [7:0]        drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [2:0] TYPE_HDR  = 3'b001;
  localparam logic [2:0] TYPE_TAIL = 3'b100;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state, state_next;
  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              empty, full, push, pop, latch_len;
  logic [FLIT_W-1:0] head;
  logic [2:0]        head_type;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign ready_out = !full;
  assign push      = valid_in && !full;
  assign head      = mem[rd_ptr];
  assign head_type = head[FLIT_W-1 -: 3];
  assign flit_out  = empty ? '0 : head;
  assign flit_id   = empty ? '0 : head_type;
  assign req       = (state == ACTIVE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, pop and length-latch decisions from the head flit.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    latch_len  = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (head_type == TYPE_HDR) begin
            state_next = ACTIVE;
            latch_len  = 1'b1;
          end else begin
            pop = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (gnt && !empty) begin
          pop = 1'b1;
          if (head_type == TYPE_TAIL) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage array; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= flit_in;
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-two DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Packet length captured when a header starts a packet.
  always_ff @(posedge clk) begin
    if (rst)            length <= '0;
    else if (latch_len) length <= head[11:0];
  end

`ifdef INPUT_BUF_DROP_COUNT_EN
  logic       drop;
  logic [7:0] drop_q;

  assign drop     = (state == IDLE) && !empty && (head_type != TYPE_HDR);
  assign drop_cnt = drop_q;

  // Saturating count of flits discarded while idle.
  always_ff @(posedge clk) begin
    if (rst)                          drop_q <= '0;
    else if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: doc/input_port_buffer.md
INPUT_PORT_BUFFER -- requirements
Module: input_port_buffer

Interface
REQ-001 Parameter FLIT_W, default 32: flit width in bits; minimum 16.
REQ-002 Parameter DEPTH, default 4: FIFO depth in flits; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 flit_in  input  FLIT_W  flit from the upstream link.
REQ-006 valid_in  input  1  flit_in valid.
REQ-007 ready_out  output  1  buffer can accept a flit this cycle.
REQ-008 flit_out  output  FLIT_W  FIFO head flit to the crossbar.
REQ-009 flit_id  output  3  head flit type, to the arbiter.
REQ-010 length  output  12  latched packet length, to the arbiter.
REQ-011 req  output  1  request to the arbiter.
REQ-012 gnt  input  1  port granted; pop the head flit this cycle.
REQ-013 drop_cnt  output  8  malformed-flit drop count.

Function
REQ-014 Flit fields: type = flit[FLIT_W-1:FLIT_W-3]; header = 3'b001, body = 3'b010, tail = 3'b100; header length = flit[11:0].
REQ-015 Push SHALL occur when valid_in && ready_out; ready_out = !full, computed from registered occupancy.
REQ-016 A pushed flit SHALL appear at flit_out one cycle after the push cycle; FIFO order SHALL be strict and pointers SHALL wrap modulo DEPTH.
REQ-017 When the FIFO is empty, flit_out and flit_id SHALL be 0; otherwise they SHALL present the head flit and its type.
REQ-018 The state machine SHALL have two states, IDLE and ACTIVE.
REQ-019 IDLE, non-empty, head type is header: go to ACTIVE and latch length from the head; no pop.
REQ-020 IDLE, non-empty, head type is not header: pop and discard the head, one flit per cycle.
REQ-021 IDLE, empty: stay in IDLE.
REQ-022 req SHALL be 1 exactly while in ACTIVE.
REQ-023 ACTIVE, gnt && non-empty: pop the head. If the popped flit is a tail, go to IDLE; otherwise stay in ACTIVE.
REQ-024 ACTIVE, gnt && empty: no pop, no state change (stall); the pointers SHALL not move.
REQ-025 ACTIVE, !gnt: hold state and FIFO contents.
REQ-026 gnt SHALL be ignored in IDLE.
REQ-027 length SHALL hold its latched value until the next header is latched.
REQ-028 Push and pop in the same cycle SHALL leave occupancy unchanged. A full FIFO refuses the push (ready_out = 0), so push-while-full cannot occur.
REQ-029 A header arriving at the head while ACTIVE (missing tail) SHALL be forwarded as an ordinary flit; only a tail ends the packet.

Reset
REQ-030 On rst the block SHALL:
- empty the FIFO (pointers and occupancy = 0);
- set the state to IDLE;
- clear length and drop_cnt to 0;
- give req = 0, flit_out = 0, flit_id = 0, and ready_out = 1 on the first cycle after reset.
REQ-031 rst asserted mid-packet SHALL discard all buffered flits, with no partial forwarding afterwards.

Configuration
REQ-032 Macro INPUT_BUF_DROP_COUNT_EN.
- Defined: drop_cnt SHALL increment by 1 on each discard per REQ-020, saturating at 255.
- Undefined: drop_cnt SHALL be tied to 0 and no counter logic SHALL be built; all other behaviour is identical.

Verification
REQ-033 Reset, then push header (length 12'd5), body, tail on consecutive cycles with gnt = 0 -> req = 1 from the cycle after the header reaches the head; length = 5; ready_out = 1 while occupancy < DEPTH.
REQ-034 Packet from REQ-033 buffered, then gnt = 1 for 3 cycles -> flit_id at head reads 001, 010, 100; req = 0 in the cycle after the tail pops; FIFO empty.
REQ-035 Push DEPTH = 4 flits with no grant -> ready_out = 0, a 5th valid_in is not accepted; then push and pop together at occupancy 3 -> occupancy stays 3.
REQ-036 In IDLE, push body, body, header -> two discards, then ACTIVE. With INPUT_BUF_DROP_COUNT_EN, drop_cnt = 2; without it, drop_cnt = 0.
REQ-037 ACTIVE with gnt held high and FIFO empty for 3 cycles, then a tail is pushed -> state stays ACTIVE and pointers are unchanged until the tail arrives; the tail pops one cycle after its push, then IDLE.
REQ-038 rst pulsed while ACTIVE with 2 flits buffered -> next cycle req = 0, flit_id = 0, ready_out = 1, length = 0.
